// File: rtl/mci_mcu_halt_rst_responder.sv
// MCU-side responder for the MCI boot FSM hitless-update handshake.
// It stalls the MCU core on a halt request and acknowledges once the core is quiet.
// On a reset request it holds the MCU in reset for RST_CYCLES cycles, then pulses rst_done.
//
// Handshake semantics:
//   halt_req  : level from the boot FSM; keep it high for as long as the halt is wanted.
//   halted    : level ack; high while the MCU is stalled (HALTED) or held in reset (RESET).
//   rst_req   : single-cycle pulse. It is honoured only in HALTED; in any other state it is ignored.
//   rst_done  : single-cycle pulse on the first RELEASE cycle.
//               halt_req must then drop before a new halt can start.
module mci_mcu_halt_rst_responder #(
    parameter int RST_CYCLES   = 10,
    parameter int HALT_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       halt_req,
    input  logic       rst_req,
    input  logic       core_quiesced,
    output logic       core_halt,
    output logic       halted,
    output logic       mcu_rst,
    output logic       rst_done,
    output logic       halt_timeout,
    output logic [2:0] fsm_state
);

    localparam int MAX_LIM = (RST_CYCLES > HALT_TIMEOUT) ? RST_CYCLES : HALT_TIMEOUT;
    localparam int CNT_W   = $clog2(MAX_LIM + 1);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] HALT_LAST = CNT_W'(HALT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALTING = 3'd1,
        ST_HALTED  = 3'd2,
        ST_RESET   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating increment; the counter is shared by the halt timeout and the reset hold.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    assign fsm_state = state;

    // Single sequencer: the next state and every registered output are updated together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            core_halt    <= 1'b0;
            halted       <= 1'b0;
            mcu_rst      <= 1'b0;
            rst_done     <= 1'b0;
            halt_timeout <= 1'b0;
        end else begin
            rst_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (halt_req) begin
                        state     <= ST_HALTING;
                        cnt       <= '0;
                        core_halt <= 1'b1;
                    end
                end
                ST_HALTING: begin
                    cnt <= cnt_inc;
                    // Quiescence beats both abort and timeout in the same cycle.
                    if (core_quiesced) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end else if (!halt_req) begin
                        state     <= ST_IDLE;
                        core_halt <= 1'b0;
                    end else if (cnt == HALT_LAST) begin
                        state        <= ST_HALTED;
                        halted       <= 1'b1;
                        halt_timeout <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    // A reset request wins over a simultaneous halt_req drop.
                    if (rst_req) begin
                        state   <= ST_RESET;
                        cnt     <= '0;
                        mcu_rst <= 1'b1;
                    end else if (!halt_req) begin
                        state     <= ST_IDLE;
                        core_halt <= 1'b0;
                        halted    <= 1'b0;
                    end
                end
                ST_RESET: begin
                    cnt <= cnt_inc;
                    if (cnt == RST_LAST) begin
                        state     <= ST_RELEASE;
                        mcu_rst   <= 1'b0;
                        halted    <= 1'b0;
                        core_halt <= 1'b0;
                        rst_done  <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    // halt_req may still be high from this update.
                    // Wait for it to drop so it does not start another halt.
                    if (!halt_req) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    core_halt <= 1'b0;
                    halted    <= 1'b0;
                    mcu_rst   <= 1'b0;
                end
            endcase
        end
    end

endmodule
